// File: rtl/srf_stream_agu_pkg.sv
// Shared types and constants for the SRF stream address generator.
// Holds the controller state encoding, the descriptor layout and the lane geometry.
package srf_stream_agu_pkg;

  localparam int unsigned SRF_LANES      = 8;
  localparam int unsigned SRF_WIDE_WIDTH = 256;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    REQ,
    PUSH,
    DONE
  } agu_state_t;

  typedef struct packed {
    logic [31:0] base;
    logic [15:0] stride;
    logic [15:0] count;
    logic        dir;
  } stream_desc_t;

endpackage

// File: rtl/srf_beat_buf.sv
// LANES x 32-bit beat register shared by the gather pack and scatter unpack paths.
// Supports a whole-beat load, a single-lane write, a clear and a filled-lane count.
module srf_beat_buf
  import srf_stream_agu_pkg::*;
#(
  parameter  int unsigned LANES = SRF_LANES,
  localparam int unsigned LW    = $clog2(LANES),
  localparam int unsigned FW    = $clog2(LANES + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  load,
  input  logic [LANES*32-1:0]   load_data,
  input  logic                  wr,
  input  logic [LW-1:0]         wr_lane,
  input  logic [31:0]           wr_data,
  input  logic [LW-1:0]         rd_lane,
  output logic [31:0]           rd_data,
  output logic [LANES*32-1:0]   beat,
  output logic [FW-1:0]         filled
);

  logic [31:0] lane_q [LANES];

  // clr outranks load and wr so a consumed beat never leaks into the next one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < LANES; i++) lane_q[i] <= '0;
      filled <= '0;
    end else if (clr) begin
      for (int unsigned i = 0; i < LANES; i++) lane_q[i] <= '0;
      filled <= '0;
    end else if (load) begin
      for (int unsigned i = 0; i < LANES; i++) lane_q[i] <= load_data[i*32 +: 32];
      filled <= FW'(LANES);
    end else if (wr) begin
      lane_q[wr_lane] <= wr_data;
      filled          <= filled + FW'(1);
    end
  end

  assign rd_data = lane_q[rd_lane];

  always_comb begin
    beat = '0;
    for (int unsigned i = 0; i < LANES; i++) beat[i*32 +: 32] = lane_q[i];
  end

endmodule

// File: rtl/srf_stream_agu.sv
// Stream address generator and lane packer in front of the SRF memory tile.
// Gather packs tile reads into wide beats; scatter unpacks wide beats into tile writes.
module srf_stream_agu
  import srf_stream_agu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned CNT_WIDTH    = 16,
  parameter int unsigned STRIDE_WIDTH = 16,
  parameter int unsigned LANES        = SRF_LANES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    desc_valid,
  output logic                    desc_ready,
  input  logic [ADDR_WIDTH-1:0]   desc_base,
  input  logic [STRIDE_WIDTH-1:0] desc_stride,
  input  logic [CNT_WIDTH-1:0]    desc_count,
  input  logic                    desc_dir,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_read_req,
  output logic                    mem_write_req,
  output logic [31:0]             mem_wr_data,
  input  logic                    mem_ack,
  input  logic [31:0]             mem_rd_data,
  output logic [LANES*32-1:0]     out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic [3:0]              out_lanes,
  input  logic [LANES*32-1:0]     in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned LW = $clog2(LANES);
  localparam int unsigned FW = $clog2(LANES + 1);

  agu_state_t              state;
  logic [STRIDE_WIDTH-1:0] stride_q;
  logic [CNT_WIDTH-1:0]    count_q;
  logic [CNT_WIDTH-1:0]    idx;
  logic [LW-1:0]           lane;
  logic                    dir_q;

  logic                    accept, ack_hit, last_word, beat_end;
  logic                    buf_clr, buf_load, buf_wr;
  logic [31:0]             buf_rd;
  logic [LANES*32-1:0]     buf_beat;
  logic [FW-1:0]           buf_filled;

  assign accept    = (state == IDLE) && desc_valid && desc_ready;
  assign ack_hit   = (state == REQ) && mem_ack;
  assign last_word = (idx + CNT_WIDTH'(1)) == count_q;
  assign beat_end  = (lane == LW'(LANES - 1)) || last_word;
  assign buf_clr   = accept || ((state == PUSH) && out_ready);
  assign buf_load  = (state == LOAD) && in_valid && in_ready;
  assign buf_wr    = ack_hit && !dir_q;

  srf_beat_buf #(.LANES(LANES)) u_beat_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (buf_clr),
    .load      (buf_load),
    .load_data (in_data),
    .wr        (buf_wr),
    .wr_lane   (lane),
    .wr_data   (mem_rd_data),
    .rd_lane   (lane),
    .rd_data   (buf_rd),
    .beat      (buf_beat),
    .filled    (buf_filled)
  );

  // Data paths read the beat register directly; gating keeps them at zero outside their phase
  assign mem_wr_data = mem_write_req ? buf_rd : '0;
  assign out_data    = out_valid ? buf_beat : '0;
  assign out_lanes   = out_valid ? 4'(buf_filled) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      stride_q      <= '0;
      count_q       <= '0;
      idx           <= '0;
      lane          <= '0;
      dir_q         <= 1'b0;
      desc_ready    <= 1'b0;
      mem_addr      <= '0;
      mem_read_req  <= 1'b0;
      mem_write_req <= 1'b0;
      out_valid     <= 1'b0;
      out_last      <= 1'b0;
      in_ready      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          desc_ready <= 1'b1;
          if (accept) begin
            desc_ready <= 1'b0;
            busy       <= 1'b1;
            stride_q   <= desc_stride;
            count_q    <= desc_count;
            dir_q      <= desc_dir;
            mem_addr   <= desc_base;
            idx        <= '0;
            lane       <= '0;
            if (desc_count == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (!desc_dir) begin
              state        <= REQ;
              mem_read_req <= 1'b1;
            end else begin
              state    <= LOAD;
              in_ready <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (in_valid) begin
            in_ready      <= 1'b0;
            mem_write_req <= 1'b1;
            state         <= REQ;
          end
        end
        REQ: begin
          // Request stays asserted across consecutive words, so each acked cycle moves one word
          if (mem_ack) begin
            mem_addr <= mem_addr + ADDR_WIDTH'(stride_q);
            idx      <= idx + CNT_WIDTH'(1);
            lane     <= lane + LW'(1);
            if (beat_end) begin
              mem_read_req  <= 1'b0;
              mem_write_req <= 1'b0;
              if (!dir_q) begin
                state     <= PUSH;
                out_valid <= 1'b1;
                out_last  <= last_word;
              end else if (last_word) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state    <= LOAD;
                in_ready <= 1'b1;
              end
            end
          end
        end
        PUSH: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (out_last) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state        <= REQ;
              mem_read_req <= 1'b1;
            end
          end
        end
        DONE: begin
          done       <= 1'b0;
          busy       <= 1'b0;
          desc_ready <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_srf_stream_agu.sv
// Self-checking bench for srf_stream_agu: a stream-level model predicts every tile
// request and gather beat, and a negedge monitor compares the DUT against it.
module tb_srf_stream_agu;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         desc_valid = 1'b0;
  logic         desc_ready;
  logic [31:0]  desc_base = '0;
  logic [15:0]  desc_stride = '0;
  logic [15:0]  desc_count = '0;
  logic         desc_dir = 1'b0;
  logic [31:0]  mem_addr;
  logic         mem_read_req, mem_write_req;
  logic [31:0]  mem_wr_data;
  logic         mem_ack;
  logic [31:0]  mem_rd_data;
  logic [255:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         out_last;
  logic [3:0]   out_lanes;
  logic [255:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         busy, done;
  logic         ack_en = 1'b1;

  always #5 clk = ~clk;

  // Tile model: zero-latency ack, read data is a fixed function of the address
  assign mem_ack     = (mem_read_req | mem_write_req) & ack_en;
  assign mem_rd_data = mem_addr ^ 32'hC3C3_0000;

  srf_stream_agu #(
    .ADDR_WIDTH  (32),
    .CNT_WIDTH   (16),
    .STRIDE_WIDTH(16),
    .LANES       (8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_base(desc_base),
    .desc_stride(desc_stride), .desc_count(desc_count), .desc_dir(desc_dir),
    .mem_addr(mem_addr), .mem_read_req(mem_read_req), .mem_write_req(mem_write_req),
    .mem_wr_data(mem_wr_data), .mem_ack(mem_ack), .mem_rd_data(mem_rd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_lanes(out_lanes),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .busy(busy), .done(done)
  );

  typedef struct {
    logic [255:0] data;
    logic [3:0]   lanes;
    logic         last;
  } beat_t;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0]  exp_addr[$];
  logic [31:0]  exp_wdata[$];
  beat_t        exp_beat[$];
  logic         exp_dir;
  logic [31:0]  addr_log[$];
  beat_t        beat_log[$];
  logic [255:0] sc_beats[2];
  int           nbeats = 0;
  int           in_hs = 0;
  int           done_cnt = 0;
  int           stall_left = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Stream model: element i lives at base + i*stride (mod 2^32), beats hold 8 elements
  task automatic build(input logic [31:0] base, input logic [15:0] stride,
                       input int count, input logic dir);
    beat_t b;
    logic [31:0] a;
    exp_addr.delete(); exp_wdata.delete(); exp_beat.delete();
    exp_dir = dir;
    b.data = '0; b.lanes = '0; b.last = 1'b0;
    for (int i = 0; i < count; i++) begin
      a = base + 32'(i) * {16'h0, stride};
      exp_addr.push_back(a);
      if (dir) begin
        exp_wdata.push_back(sc_beats[i / 8][(i % 8) * 32 +: 32]);
      end else begin
        b.data[(i % 8) * 32 +: 32] = a ^ 32'hC3C3_0000;
        b.lanes++;
        if ((i % 8) == 7 || i == count - 1) begin
          b.last = (i == count - 1);
          exp_beat.push_back(b);
          b.data = '0; b.lanes = '0; b.last = 1'b0;
        end
      end
    end
    nbeats = (count + 7) / 8;
  endtask

  logic         prev_done = 1'b0, prev_stall = 1'b0, p_last;
  logic [255:0] p_data;
  logic [3:0]   p_lanes;
  beat_t        mb, ab;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_done  = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (done) chk("done_one_cycle", prev_done, 1'b0);
      if (done && !prev_done) done_cnt++;
      prev_done = done;
      if (busy) chk("ready_while_busy", desc_ready, 1'b0);
      if ((mem_read_req | mem_write_req) && mem_ack) begin
        chk("req_expected", exp_addr.size() != 0, 1'b1);
        if (exp_addr.size() != 0) begin
          addr_log.push_back(mem_addr);
          chk("mem_addr", mem_addr, exp_addr.pop_front());
          chk("req_dir", {mem_read_req, mem_write_req}, exp_dir ? 2'b01 : 2'b10);
          if (exp_dir) chk("mem_wr_data", mem_wr_data, exp_wdata.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        chk("in_ready_extra", in_hs < nbeats, 1'b1);
        in_hs++;
      end
      if (out_valid) begin
        chk("req_during_push", mem_read_req, 1'b0);
        if (prev_stall) begin
          chk("hold_data", out_data, p_data);
          chk("hold_lanes", out_lanes, p_lanes);
          chk("hold_last", out_last, p_last);
        end
        if (out_ready) begin
          chk("beat_expected", exp_beat.size() != 0, 1'b1);
          if (exp_beat.size() != 0) begin
            mb = exp_beat.pop_front();
            ab.data = out_data; ab.lanes = out_lanes; ab.last = out_last;
            beat_log.push_back(ab);
            chk("out_data", out_data, mb.data);
            chk("out_lanes", out_lanes, mb.lanes);
            chk("out_last", out_last, mb.last);
          end
        end
      end else if (prev_stall) begin
        chk("valid_dropped", out_valid, 1'b1);
      end
      prev_stall = out_valid && !out_ready;
      p_data = out_data; p_lanes = out_lanes; p_last = out_last;
    end
  end

  task automatic send_desc(input logic [31:0] base, input logic [15:0] stride,
                           input logic [15:0] count, input logic dir);
    logic ok = 1'b0;
    desc_base = base; desc_stride = stride; desc_count = count; desc_dir = dir;
    desc_valid = 1'b1;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      ok = desc_ready;
      @(posedge clk); #1;
    end
    desc_valid = 1'b0;
    chk("desc_accept", ok, 1'b1);
  endtask

  task automatic run(input logic [31:0] base, input logic [15:0] stride,
                     input logic [15:0] count, input logic dir, input int stall);
    int d0;
    build(base, stride, int'(count), dir);
    addr_log.delete(); beat_log.delete();
    in_hs = 0;
    stall_left = stall;
    out_ready = (stall == 0);
    d0 = done_cnt;
    send_desc(base, stride, count, dir);
    if (count == 0) begin
      @(negedge clk);
      chk("done_after_accept", done, 1'b1);
    end
    for (int c = 0; c < 400 && done_cnt == d0; c++) begin
      @(posedge clk); #1;
      in_valid = dir && (in_hs < nbeats);
      if (in_hs < nbeats) in_data = sc_beats[in_hs];
      if (out_valid && stall_left > 0) stall_left--;
      out_ready = (stall_left == 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("done_pulses", done_cnt - d0, 1);
    chk("busy_after", busy, 1'b0);
    chk("addr_left", exp_addr.size(), 0);
    chk("beats_left", exp_beat.size(), 0);
    if (dir) chk("in_handshakes", in_hs, nbeats);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("reset_ctrl", {desc_ready, mem_addr, mem_read_req, mem_write_req, mem_wr_data,
                       out_valid, out_last, out_lanes, in_ready, busy, done}, '0);
    chk("reset_out_data", out_data, '0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Gather, two beats, second one partial
    run(32'h0000_0100, 16'd8, 16'd10, 1'b0, 0);
    chk("g1_addr0", addr_log[0], 32'h0000_0100);
    chk("g1_addr9", addr_log[9], 32'h0000_0148);
    chk("g1_nbeats", beat_log.size(), 2);
    if (beat_log.size() == 2) begin
      chk("g1_b0_lanes", beat_log[0].lanes, 4'd8);
      chk("g1_b0_last", beat_log[0].last, 1'b0);
      chk("g1_b1_lanes", beat_log[1].lanes, 4'd2);
      chk("g1_b1_last", beat_log[1].last, 1'b1);
      chk("g1_b1_lane1", beat_log[1].data[63:32], 32'hC3C3_0148);
      chk("g1_b1_zero", beat_log[1].data[255:64], '0);
    end

    // Empty stream
    run(32'h0000_0200, 16'd4, 16'd0, 1'b0, 0);
    chk("z_no_req", addr_log.size(), 0);
    chk("z_no_beat", beat_log.size(), 0);

    // Scatter one full beat
    for (int i = 0; i < 8; i++) sc_beats[0][i*32 +: 32] = 32'h0000_00A0 + 32'(i);
    run(32'h0000_0040, 16'd4, 16'd8, 1'b1, 0);
    chk("s1_writes", addr_log.size(), 8);
    chk("s1_addr7", addr_log[7], 32'h0000_005C);

    // Gather with consumer back-pressure
    run(32'h0000_0300, 16'd4, 16'd8, 1'b0, 6);
    chk("st_lanes", beat_log[0].lanes, 4'd8);
    chk("st_last", beat_log[0].last, 1'b1);

    // Address wrap past 2^32
    run(32'hFFFF_FFF8, 16'd8, 16'd3, 1'b0, 0);
    chk("w_addr0", addr_log[0], 32'hFFFF_FFF8);
    chk("w_addr1", addr_log[1], 32'h0000_0000);
    chk("w_addr2", addr_log[2], 32'h0000_0008);

    // Scatter partial second beat with stride 0
    for (int i = 0; i < 8; i++) sc_beats[1][i*32 +: 32] = 32'h0000_00B0 + 32'(i);
    run(32'h0000_1000, 16'd0, 16'd10, 1'b1, 0);
    chk("s2_addr9", addr_log[9], 32'h0000_1000);

    // Reset while a request is waiting for its ack
    ack_en = 1'b0;
    build(32'h0000_0400, 16'd4, 10, 1'b0);
    send_desc(32'h0000_0400, 16'd4, 16'd10, 1'b0);
    begin
      int d0;
      d0 = done_cnt;
      repeat (3) @(posedge clk);
      #1;
      chk("r_req_held", mem_read_req, 1'b1);
      chk("r_addr_held", mem_addr, 32'h0000_0400);
      #2 rst_n = 1'b0;
      #1;
      chk("r_ctrl_zero", {desc_ready, mem_addr, mem_read_req, mem_write_req, mem_wr_data,
                          out_valid, out_last, out_lanes, in_ready, busy, done}, '0);
      chk("r_data_zero", out_data, '0);
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      ack_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("r_no_done", done_cnt - d0, 0);
    end
    run(32'h0000_0500, 16'd12, 16'd9, 1'b0, 0);
    chk("r2_addr8", addr_log[8], 32'h0000_0560);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
